// File: rtl/branch_target_buffer_pkg.sv
// Shared pipeline constants and index/tag width helpers for the branch target buffer.
package branch_target_buffer_pkg;

    localparam int XLEN            = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam int DEFAULT_ENTRIES = 16;
    localparam int DEFAULT_CNT_W   = 16;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // PC bits [1:0] are dropped, the index sits above them, the tag takes the rest.
    function automatic int tag_width(input int entries);
        return XLEN - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count register: clear wins over increment, increment stops at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {WIDTH{1'b0}};
        end else if (clr) begin
            count <= {WIDTH{1'b0}};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, flop-based branch target buffer with combinational lookup and
// saturating lookup/hit statistics.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_en,
    input  logic [XLEN-1:0]  pc_f,
    input  logic             predict_taken,
    output logic             hit,
    output logic [XLEN-1:0]  pred_target,
    output logic [XLEN-1:0]  pc_pred,
    input  logic             upd_en,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             inv_all,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int TAG_W = tag_width(ENTRIES);

    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [XLEN-1:0]    target_r [ENTRIES];

    logic [IDX_W-1:0] idx_f_s;
    logic [TAG_W-1:0] tag_f_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [TAG_W-1:0] upd_tag_s;
    logic             wr_en_s;
    logic             hit_s;
    logic             unused_s;

    assign idx_f_s   = pc_f[IDX_W+1:2];
    assign tag_f_s   = pc_f[XLEN-1:IDX_W+2];
    assign upd_idx_s = upd_pc[IDX_W+1:2];
    assign upd_tag_s = upd_pc[XLEN-1:IDX_W+2];
    assign unused_s  = ^{pc_f[1:0], upd_pc[1:0]};

    // A same-cycle flush drops the update; not-taken resolutions never touch the table.
    assign wr_en_s = upd_en & upd_taken & ~inv_all;

    // Valid bits: the only table state that needs reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (inv_all) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (wr_en_s) begin
            valid_r[upd_idx_s] <= 1'b1;
        end
    end

    // Tag and target payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_r[upd_idx_s]    <= upd_tag_s;
            target_r[upd_idx_s] <= upd_target;
        end
    end

    // Lookup reads the pre-edge table, so a same-cycle write is seen only next cycle.
    assign hit_s       = lookup_en & valid_r[idx_f_s] & (tag_r[idx_f_s] == tag_f_s);
    assign hit         = hit_s;
    assign pred_target = target_r[idx_f_s];
    assign pc_pred     = (hit_s & predict_taken) ? target_r[idx_f_s] : (pc_f + PC_INC);

    sat_counter #(.WIDTH(CNT_W)) u_lookup_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (lookup_en),
        .count (lookup_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (hit_s),
        .count (hit_cnt)
    );

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, giving the number of direct-mapped entries; it SHALL be a power of two, from 4 to 256.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- lookup_en  in  1  IF-stage lookup valid.
- pc_f  in  32  fetch PC.
- predict_taken  in  1  direction bit from the one-bit predictor for the current fetch.
- hit  out  1  valid entry whose tag matches pc_f.
- pred_target  out  32  stored target of the indexed entry.
- pc_pred  out  32  predicted next fetch PC.
- upd_en  in  1  EX-stage resolved control-transfer instruction.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  32  resolved target.
- inv_all  in  1  invalidate all entries (fence.i / context flush).
- lookup_cnt  out  CNT_W  saturating count of lookups.
- hit_cnt  out  CNT_W  saturating count of hits.

Function
REQ-004 Index SHALL be pc[IDX_W+1:2], where IDX_W = log2(ENTRIES); tag SHALL be pc[31:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-005 Each entry SHALL hold a valid bit, a tag and a 32-bit target.
REQ-006 Lookup SHALL be combinational, with zero-cycle latency from pc_f: hit = lookup_en & valid[idx] & (tag[idx] == tag(pc_f)).
REQ-007 pred_target SHALL always reflect the target of the indexed entry, regardless of hit.
REQ-008 pc_pred SHALL be pred_target when hit & predict_taken, and pc_f + 4 (modulo 2^32) otherwise; 0xFFFFFFFC SHALL wrap to 0x00000000.
REQ-009 On upd_en & upd_taken, the entry at idx(upd_pc) SHALL be written with valid=1, tag(upd_pc) and upd_target on the next rising edge; any existing entry at that index SHALL be overwritten (aliasing replacement).
REQ-010 On upd_en & ~upd_taken, the table SHALL be left unchanged; the direction is owned by the predictor.
REQ-011 On inv_all, all valid bits SHALL clear on the next edge; inv_all SHALL take priority over a same-cycle update, which is dropped.
REQ-012 Write and lookup to the same index in the same cycle: the lookup SHALL see the pre-write contents (no bypass); the new entry SHALL be visible from the following cycle.
REQ-013 lookup_cnt SHALL increment on each cycle with lookup_en=1.
REQ-014 hit_cnt SHALL increment on each cycle with hit=1.
REQ-015 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-016 Counters SHALL be unaffected by inv_all.
REQ-017 With lookup_en=0, hit SHALL be 0; pc_pred SHALL still equal pc_f + 4.

Reset
REQ-018 While rst_n=0, all valid bits, lookup_cnt and hit_cnt SHALL be 0, and hit SHALL be 0.
REQ-019 Tag and target arrays need not be reset.
REQ-020 Reset asserted mid-operation SHALL discard any pending update in that cycle.
REQ-021 After rst_n deasserts, the first lookup SHALL miss.

Structure
REQ-022 The following SHALL live in the shared pipeline package:
- XLEN (32);
- the PC increment constant (4);
- default ENTRIES and CNT_W;
- the index/tag width derivation.
REQ-023 A single sub-module, sat_counter (parameter width; inputs inc and clr), SHALL be instantiated twice for the statistics counters.
REQ-024 The storage SHALL be flip-flop based (no SRAM macro) for this pipeline.

Verification
REQ-025 Reset then lookup pc_f=0x00000100 with predict_taken=1 -> hit=0, pc_pred=0x00000104, lookup_cnt=1, hit_cnt=0.
REQ-026 Update upd_pc=0x00000100, taken, target 0x00000200; next cycle lookup 0x00000100 with predict_taken=1 -> hit=1, pc_pred=0x00000200; with predict_taken=0 -> pc_pred=0x00000104.
REQ-027 Alias overwrite (ENTRIES=16):
- stimulus: after REQ-026, update upd_pc=0x00000140 taken to 0x00000300, then look up 0x00000100 and 0x00000140;
- required: lookup 0x00000100 -> hit=0; lookup 0x00000140 -> hit=1, target 0x00000300.
REQ-028 Same-cycle update and lookup:
- stimulus: same-cycle update and lookup of 0x00000180 on an empty entry;
- required: hit=0 that cycle and hit=1 the next cycle;
- stimulus: inv_all together with an update;
- required: the table ends empty.
REQ-029 pc_f=0xFFFFFFFC, miss -> pc_pred=0x00000000.
REQ-030 With CNT_W=4, 20 consecutive hits -> hit_cnt=15, held at 15.
REQ-031 rst_n pulsed low mid-stream -> hit_cnt=0 and all subsequent lookups miss until re-trained.
